// File: rtl/accum_pkg.sv
// Shared defaults and saturation limits for the channelised accumulator.
package accum_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 18;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_LEN    = 16;
    localparam int LIM_W      = 64;

    function automatic logic [LIM_W-1:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Low w bits hold the most negative w-bit value.
    function automatic logic [LIM_W-1:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Sign-extending saturating adder: acc + data clamped to the ACC_W range.
module sat_add
    import accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] a_x;
    logic [ACC_W:0] d_x;
    logic [ACC_W:0] s_x;

    assign a_x = {acc[ACC_W-1], acc};
    assign d_x = {{(ACC_W + 1 - DATA_W){data[DATA_W-1]}}, data};
    assign s_x = a_x + d_x;

    // One guard bit: top two bits differ only on overflow.
    assign ovf = s_x[ACC_W] ^ s_x[ACC_W-1];

    always_comb begin
        sum = s_x[ACC_W-1:0];
        if (ovf) begin
            sum = s_x[ACC_W] ? MIN : MAX;
        end
    end

endmodule

// File: rtl/accum_sat_chan.sv
// Per-channel saturating accumulator emitting one sum every LEN samples.
module accum_sat_chan
    import accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int LEN    = DEF_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [ch_w(NUM_CH)-1:0]   in_ch,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [ch_w(NUM_CH)-1:0]   out_ch,
    output logic [ACC_W-1:0]          out_data,
    output logic                      out_sat
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(LEN);

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic             sat_q [NUM_CH];

    logic [CH_W-1:0]  sel;
    logic             ch_ok;
    logic             take;
    logic             last;
    logic             sat_nxt;
    logic             ovf;
    logic [ACC_W-1:0] sum;

    assign in_rdy = !out_vld || out_rdy;

    // Out-of-range channels are consumed but never touch state.
    assign ch_ok   = 32'(in_ch) < NUM_CH;
    assign sel     = ch_ok ? in_ch : '0;
    assign take    = in_vld && in_rdy && ch_ok;
    assign last    = cnt_q[sel] == CNT_W'(LEN - 1);
    assign sat_nxt = sat_q[sel] | ovf;

    sat_add #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc  (acc_q[sel]),
        .data (in_data),
        .sum  (sum),
        .ovf  (ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                sat_q[i] <= 1'b0;
            end
            out_vld  <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                sat_q[i] <= 1'b0;
            end
            out_vld <= 1'b0;
        end else begin
            if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
            if (take) begin
                if (last) begin
                    out_vld    <= 1'b1;
                    out_ch     <= sel;
                    out_data   <= sum;
                    out_sat    <= sat_nxt;
                    acc_q[sel] <= '0;
                    cnt_q[sel] <= '0;
                    sat_q[sel] <= 1'b0;
                end else begin
                    acc_q[sel] <= sum;
                    cnt_q[sel] <= cnt_q[sel] + 1'b1;
                    sat_q[sel] <= sat_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_sat_chan.sv
// Bench for accum_sat_chan: two configurations against a sum-of-samples model.
module tb_accum_sat_chan;

    localparam longint AMAX = 131071;
    localparam longint AMIN = -131072;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        clr_a, vld_a, ordy_a, rdy_a, ovld_a, osat_a;
    logic [1:0]  ch_a, och_a;
    logic [15:0] din_a;
    logic [17:0] od_a;

    logic        clr_b, vld_b, ordy_b, rdy_b, ovld_b, osat_b;
    logic [0:0]  ch_b, och_b;
    logic [15:0] din_b;
    logic [17:0] od_b;

    accum_sat_chan #(
        .DATA_W (16), .ACC_W (18), .NUM_CH (3), .LEN (4)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_a),
        .in_vld   (vld_a),
        .in_rdy   (rdy_a),
        .in_ch    (ch_a),
        .in_data  (din_a),
        .out_vld  (ovld_a),
        .out_rdy  (ordy_a),
        .out_ch   (och_a),
        .out_data (od_a),
        .out_sat  (osat_a)
    );

    accum_sat_chan #(
        .DATA_W (16), .ACC_W (18), .NUM_CH (2), .LEN (8)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_b),
        .in_vld   (vld_b),
        .in_rdy   (rdy_b),
        .in_ch    (ch_b),
        .in_data  (din_b),
        .out_vld  (ovld_b),
        .out_rdy  (ordy_b),
        .out_ch   (och_b),
        .out_data (od_b),
        .out_sat  (osat_b)
    );

    int total = 0;
    int bad   = 0;

    int lenv [2] = '{4, 8};
    int nchv [2] = '{3, 2};

    // Model: running sum, sample count and saturation flag per channel,
    // plus the single result slot the block presents downstream.
    longint m_sum [2][4];
    int     m_n   [2][4];
    bit     m_sat [2][4];
    bit     mv    [2];
    longint md    [2];
    int     mc    [2];
    bit     ms    [2];

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset(input int d);
        for (int c = 0; c < 4; c++) begin
            m_sum[d][c] = 0;
            m_n[d][c]   = 0;
            m_sat[d][c] = 0;
        end
        mv[d] = 0;
    endtask

    task automatic rd(input int d, output bit rdy, output bit v,
                      output int ch, output longint dat, output bit s);
        if (d == 0) begin
            rdy = rdy_a; v = ovld_a; ch = int'(och_a);
            dat = longint'($signed(od_a)); s = osat_a;
        end else begin
            rdy = rdy_b; v = ovld_b; ch = int'(och_b);
            dat = longint'($signed(od_b)); s = osat_b;
        end
    endtask

    task automatic drv(input int d, input bit v, input int ch,
                       input longint data, input bit ordy, input bit cl);
        if (d == 0) begin
            vld_a = v; ch_a = 2'(ch); din_a = 16'(data);
            ordy_a = ordy; clr_a = cl;
            vld_b = 0; clr_b = 0; ordy_b = 0;
        end else begin
            vld_b = v; ch_b = 1'(ch); din_b = 16'(data);
            ordy_b = ordy; clr_b = cl;
            vld_a = 0; clr_a = 0; ordy_a = 0;
        end
    endtask

    task automatic step(input int d, input bit v, input int ch,
                        input longint data, input bit ordy, input bit cl);
        bit rdy, ov, os, rdy_exp, acc;
        int oc;
        longint odt, s;
        @(negedge clk);
        drv(d, v, ch, data, ordy, cl);
        #1;
        rd(d, rdy, ov, oc, odt, os);
        rdy_exp = !mv[d] || ordy;
        chk("in_rdy", longint'(rdy), longint'(rdy_exp));
        chk("out_vld", longint'(ov), longint'(mv[d]));
        if (mv[d]) begin
            chk("out_ch", oc, mc[d]);
            chk("out_data", odt, md[d]);
            chk("out_sat", longint'(os), longint'(ms[d]));
        end
        acc = v && rdy_exp;
        @(posedge clk);
        if (cl) begin
            mreset(d);
        end else begin
            if (mv[d] && ordy) mv[d] = 0;
            if (acc && ch < nchv[d]) begin
                s = m_sum[d][ch] + data;
                if (s > AMAX) begin
                    s = AMAX; m_sat[d][ch] = 1;
                end else if (s < AMIN) begin
                    s = AMIN; m_sat[d][ch] = 1;
                end
                m_n[d][ch]++;
                if (m_n[d][ch] == lenv[d]) begin
                    mv[d] = 1; md[d] = s; mc[d] = ch; ms[d] = m_sat[d][ch];
                    m_sum[d][ch] = 0; m_n[d][ch] = 0; m_sat[d][ch] = 0;
                end else begin
                    m_sum[d][ch] = s;
                end
            end
        end
    endtask

    // Read outputs shortly after the edge that just completed.
    task automatic peek(input int d, input string tag, input bit v_e,
                        input int ch_e, input longint d_e, input bit s_e);
        bit rdy, v, s;
        int ch;
        longint dat;
        #2;
        rd(d, rdy, v, ch, dat, s);
        chk({tag, "_vld"}, longint'(v), longint'(v_e));
        if (v_e) begin
            chk({tag, "_ch"}, ch, ch_e);
            chk({tag, "_data"}, dat, d_e);
            chk({tag, "_sat"}, longint'(s), longint'(s_e));
        end
    endtask

    task automatic reset_check(input string tag);
        bit rdy, v, s;
        int ch;
        longint dat;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            rd(d, rdy, v, ch, dat, s);
            chk({tag, "_vld"}, longint'(v), 0);
            chk({tag, "_ch"}, ch, 0);
            chk({tag, "_data"}, dat, 0);
            chk({tag, "_sat"}, longint'(s), 0);
            mreset(d);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk({tag, "_rdy_a"}, longint'(rdy_a), 1);
        chk({tag, "_rdy_b"}, longint'(rdy_b), 1);
    endtask

    function automatic longint rnd_data();
        logic signed [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            r = 16'($urandom_range(32000, 32767));
            if ($urandom_range(0, 1) == 1) r = -r;
        end
        return longint'(r);
    endfunction

    initial begin
        rst_n = 0;
        drv(0, 0, 0, 0, 0, 0);
        mreset(0);
        mreset(1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld_a", longint'(ovld_a), 0);
        chk("rst_data_a", longint'($signed(od_a)), 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 1; i <= 4; i++) step(0, 1, 0, i, 1, 0);
        peek(0, "sum1234", 1, 0, 10, 0);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(0, 1, 0, 100, 1, 0);
            else step(0, 1, 1, -50, 1, 0);
            if (i == 6) peek(0, "ilv_ch0", 1, 0, 400, 0);
            if (i == 7) peek(0, "ilv_ch1", 1, 1, -200, 0);
        end
        step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 4; i++) step(0, 1, 0, 2, 0, 0);
        peek(0, "stall_a", 1, 0, 8, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 9, 0, 0);
            chk("stall_rdy", longint'(rdy_a), 0);
        end
        peek(0, "stall_b", 1, 0, 8, 0);
        step(0, 0, 0, 0, 1, 0);
        peek(0, "drain", 0, 0, 0, 0);

        step(0, 1, 0, 5, 1, 0);
        step(0, 1, 0, 5, 1, 0);
        step(0, 1, 0, 7, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1, 0);
        peek(0, "clr_sum", 1, 0, 4, 0);
        step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 8; i++) step(1, 1, 0, 32767, 1, 0);
        peek(1, "sat_hi", 1, 0, 131071, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 1, 0);
        peek(1, "sat_clr", 1, 0, 8, 0);
        step(1, 0, 0, 0, 1, 0);

        for (int i = 0; i < 500; i++) begin
            if (i == 250) reset_check("mid_rst");
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 rnd_data(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0);
        end
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                 rnd_data(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 79) == 0);
        end
        step(1, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
